// File: rtl/dump_ctrl.sv
// Dump controller: reads channel calibration from the EEPROM over SPI,
// then streams 512 trace samples from RAM out through the UART path.
module dump_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        dump,
  input  logic [1:0]  dump_ch,
  input  logic [2:0]  ch1_AFEgain,
  input  logic [2:0]  ch2_AFEgain,
  input  logic [2:0]  ch3_AFEgain,
  input  logic [8:0]  trace_end,
  input  logic        SPI_done,
  input  logic        resp_sent,
  output logic        wrt_SPI,
  output logic [2:0]  ss,
  output logic [15:0] SPI_data,
  output logic        flopOffset,
  output logic        flopGain,
  output logic        ram_rd,
  output logic [8:0]  ram_addr,
  output logic        send_resp,
  output logic        dump_busy,
  output logic        dump_done
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_OFF_A,
    S_OFF_B,
    S_GAIN_A,
    S_GAIN_B,
    S_RD,
    S_SEND,
    S_WAIT,
    S_FIN
  } state_t;

  state_t      state, nxt_state;
  logic [1:0]  ch_q;
  logic [2:0]  g_q;
  logic [8:0]  te_q;
  logic [8:0]  cnt, nxt_cnt;
  logic        nxt_wrt;
  logic [15:0] spi_q, nxt_spi;
  logic        latch;
  logic [2:0]  g_sel;
  logic [8:0]  addr_c;

  always_comb begin
    g_sel = ch1_AFEgain;
    unique case (dump_ch)
      2'b01:   g_sel = ch2_AFEgain;
      2'b10:   g_sel = ch3_AFEgain;
      default: g_sel = ch1_AFEgain;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      cnt     <= '0;
      ch_q    <= '0;
      g_q     <= '0;
      te_q    <= '0;
      wrt_SPI <= 1'b0;
      spi_q   <= '0;
    end else begin
      state   <= nxt_state;
      cnt     <= nxt_cnt;
      wrt_SPI <= nxt_wrt;
      spi_q   <= nxt_spi;
      if (latch) begin
        ch_q <= dump_ch;
        g_q  <= g_sel;
        te_q <= trace_end;
      end
    end
  end

  // Command word: channel and gain select the EEPROM entry, bit 8 picks gain vs offset.
  always_comb begin
    nxt_state  = state;
    nxt_cnt    = cnt;
    nxt_wrt    = 1'b0;
    nxt_spi    = spi_q;
    latch      = 1'b0;
    flopOffset = 1'b0;
    flopGain   = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (dump && dump_ch != 2'b11) begin
          latch     = 1'b1;
          nxt_cnt   = '0;
          nxt_wrt   = 1'b1;
          nxt_spi   = {2'b00, dump_ch, g_sel, 1'b0, 8'h00};
          nxt_state = S_OFF_A;
        end else if (dump) begin
          nxt_state = S_FIN;
        end
      end
      S_OFF_A: begin
        if (SPI_done) begin
          nxt_wrt   = 1'b1;
          nxt_spi   = 16'h0000;
          nxt_state = S_OFF_B;
        end
      end
      S_OFF_B: begin
        if (SPI_done) begin
          flopOffset = 1'b1;
          nxt_wrt    = 1'b1;
          nxt_spi    = {2'b00, ch_q, g_q, 1'b1, 8'h00};
          nxt_state  = S_GAIN_A;
        end
      end
      S_GAIN_A: begin
        if (SPI_done) begin
          nxt_wrt   = 1'b1;
          nxt_spi   = 16'h0000;
          nxt_state = S_GAIN_B;
        end
      end
      S_GAIN_B: begin
        if (SPI_done) begin
          flopGain  = 1'b1;
          nxt_state = S_RD;
        end
      end
      S_RD:   nxt_state = S_SEND;
      S_SEND: nxt_state = S_WAIT;
      S_WAIT: begin
        if (resp_sent) begin
          if (cnt == 9'd511) begin
            nxt_state = S_FIN;
          end else begin
            nxt_cnt   = cnt + 9'd1;
            nxt_state = S_RD;
          end
        end
      end
      S_FIN:   nxt_state = S_IDLE;
      default: nxt_state = S_IDLE;
    endcase
  end

  assign addr_c = te_q + 9'd1 + cnt;

  always_comb begin
    ram_addr = '0;
    if (state == S_RD || state == S_SEND || state == S_WAIT)
      ram_addr = addr_c;
  end

  assign ss        = 3'b100;
  assign SPI_data  = spi_q;
  assign ram_rd    = (state == S_RD);
  assign send_resp = (state == S_SEND);
  assign dump_busy = (state != S_IDLE);
  assign dump_done = (state == S_FIN);

endmodule

// File: tb/tb_dump_ctrl.sv
// Randomized scoreboard bench for dump_ctrl: a transaction-level model
// predicts the SPI/RAM/UART event stream of each dump.
module tb_dump_ctrl;

  localparam int K_SPI  = 1;
  localparam int K_OFF  = 2;
  localparam int K_GAIN = 3;
  localparam int K_RD   = 4;
  localparam int K_SND  = 5;
  localparam int K_DONE = 6;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        dump = 1'b0;
  logic [1:0]  dump_ch = 2'b00;
  logic [2:0]  g1 = 3'd0, g2 = 3'd0, g3 = 3'd0;
  logic [8:0]  trace_end = 9'd0;
  logic        SPI_done = 1'b0;
  logic        resp_sent = 1'b0;
  logic        wrt_SPI;
  logic [2:0]  ss;
  logic [15:0] SPI_data;
  logic        flopOffset, flopGain, ram_rd, send_resp;
  logic [8:0]  ram_addr;
  logic        dump_busy, dump_done;

  int total = 0;
  int bad = 0;
  int q[$];
  int wrt_cnt = 0;
  int snd_cnt = 0;
  int done_cnt = 0;

  dump_ctrl dut (
    .clk(clk), .rst_n(rst_n), .dump(dump), .dump_ch(dump_ch),
    .ch1_AFEgain(g1), .ch2_AFEgain(g2), .ch3_AFEgain(g3),
    .trace_end(trace_end), .SPI_done(SPI_done), .resp_sent(resp_sent),
    .wrt_SPI(wrt_SPI), .ss(ss), .SPI_data(SPI_data),
    .flopOffset(flopOffset), .flopGain(flopGain),
    .ram_rd(ram_rd), .ram_addr(ram_addr), .send_resp(send_resp),
    .dump_busy(dump_busy), .dump_done(dump_done)
  );

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog act=running req=finished");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s act=%0h req=%0h", name, act, exp);
    end
  endtask

  task automatic expect_ev(input string name, input int kind, input int val);
    int e;
    total++;
    if (q.size() == 0) begin
      bad++;
      $display("FAIL %s act=%0h req=none", name, val);
    end else begin
      e = q.pop_front();
      if (e != (kind * 65536 + val)) begin
        bad++;
        $display("FAIL %s act=%0h req=%0h", name, kind * 65536 + val, e);
      end
    end
  endtask

  // Reference model: the whole expected event stream of one dump.
  task automatic push_dump(input int ch, input int g, input int te);
    if (ch == 3) begin
      q.push_back(K_DONE * 65536);
      return;
    end
    q.push_back(K_SPI * 65536 + ch * 4096 + g * 512);
    q.push_back(K_SPI * 65536);
    q.push_back(K_OFF * 65536);
    q.push_back(K_SPI * 65536 + ch * 4096 + g * 512 + 256);
    q.push_back(K_SPI * 65536);
    q.push_back(K_GAIN * 65536);
    for (int i = 0; i < 512; i++) begin
      q.push_back(K_RD * 65536 + (te + 1 + i) % 512);
      q.push_back(K_SND * 65536 + (te + 1 + i) % 512);
    end
    q.push_back(K_DONE * 65536);
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (flopOffset) expect_ev("flopOffset", K_OFF, 0);
        if (flopGain) expect_ev("flopGain", K_GAIN, 0);
        if (wrt_SPI) begin
          wrt_cnt++;
          expect_ev("spi_word", K_SPI, int'(SPI_data));
          chk("ss", int'(ss), 4);
        end
        if (ram_rd) expect_ev("ram_rd_addr", K_RD, int'(ram_addr));
        if (send_resp) begin
          snd_cnt++;
          expect_ev("send_addr", K_SND, int'(ram_addr));
        end
        if (dump_done) begin
          done_cnt++;
          expect_ev("dump_done", K_DONE, 0);
        end
      end
    end
  end

  initial begin
    logic [15:0] w;
    forever begin
      @(negedge clk);
      if (rst_n && wrt_SPI) begin
        w = SPI_data;
        repeat ($urandom_range(1, 4)) @(posedge clk);
        #1;
        if (rst_n) begin
          SPI_done = 1'b1;
          chk("spi_hold", int'(SPI_data), int'(w));
        end
        @(posedge clk);
        #1 SPI_done = 1'b0;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && send_resp) begin
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
        if (rst_n) resp_sent = 1'b1;
        @(posedge clk);
        #1 resp_sent = 1'b0;
      end
    end
  end

  task automatic chk_reset_outs();
    chk("rst_wrt_SPI", int'(wrt_SPI), 0);
    chk("rst_ss", int'(ss), 4);
    chk("rst_SPI_data", int'(SPI_data), 0);
    chk("rst_flopOffset", int'(flopOffset), 0);
    chk("rst_flopGain", int'(flopGain), 0);
    chk("rst_ram_rd", int'(ram_rd), 0);
    chk("rst_ram_addr", int'(ram_addr), 0);
    chk("rst_send_resp", int'(send_resp), 0);
    chk("rst_dump_busy", int'(dump_busy), 0);
    chk("rst_dump_done", int'(dump_done), 0);
  endtask

  task automatic pulse_dump(input logic [1:0] ch);
    @(posedge clk);
    #1 dump = 1'b1;
    dump_ch = ch;
    @(posedge clk);
    #1 dump = 1'b0;
    dump_ch = 2'($urandom_range(0, 3));
  endtask

  task automatic wait_cnt(input string name, input int which, input int target);
    int n = 0;
    while (((which == 0) ? wrt_cnt : snd_cnt) < target && n < 20000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20000) chk(name, 0, 1);
  endtask

  task automatic wait_done(input string name, input int limit);
    int d0 = done_cnt;
    int n = 0;
    while (done_cnt == d0 && n < limit) begin
      @(negedge clk);
      n++;
    end
    chk(name, done_cnt - d0, 1);
    @(posedge clk);
    #1 chk("idle_busy", int'(dump_busy), 0);
  endtask

  // mode 0: plain, 1: stray dumps in GAIN_A and WAIT, 2: reset at cnt 37
  task automatic do_dump(input int ch, input int te, input int mode);
    int g;
    int w0, s0;
    trace_end = 9'(te);
    g = (ch == 1) ? int'(g2) : (ch == 2) ? int'(g3) : int'(g1);
    push_dump(ch, g, te);
    w0 = wrt_cnt;
    s0 = snd_cnt;
    pulse_dump(2'(ch));
    g1 = 3'($urandom);
    g2 = 3'($urandom);
    g3 = 3'($urandom);
    trace_end = 9'($urandom);
    if (ch == 3) begin
      wait_done("reserved_done", 4);
      return;
    end
    if (mode == 1) begin
      wait_cnt("to_gain_a", 0, w0 + 3);
      pulse_dump(2'($urandom_range(0, 3)));
      wait_cnt("to_wait", 1, s0 + 200);
      pulse_dump(2'($urandom_range(0, 3)));
    end
    if (mode == 2) begin
      wait_cnt("to_cnt37", 1, s0 + 38);
      @(posedge clk);
      #1 rst_n = 1'b0;
      #1 chk_reset_outs();
      q.delete();
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      return;
    end
    wait_done("dump_done_seen", 20000);
  endtask

  initial begin
    #2 chk_reset_outs();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    g2 = 3'b101;
    do_dump(1, 100, 0);
    g1 = 3'($urandom);
    g2 = 3'($urandom);
    g3 = 3'($urandom);
    do_dump($urandom_range(0, 2), 511, 1);
    do_dump(3, 17, 0);
    do_dump($urandom_range(0, 2), $urandom_range(0, 511), 2);
    do_dump($urandom_range(0, 2), $urandom_range(0, 511), 0);
    for (int i = 0; i < 3; i++) begin
      do_dump($urandom_range(0, 3), $urandom_range(0, 511), 0);
    end
    repeat (5) @(posedge clk);
    chk("queue_empty", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dump_ctrl.md
DUMP_CTRL -- requirements
Module: dump_ctrl

Interface
REQ-001 Ports SHALL be as listed; clock and reset are fixed: one clock, reset asynchronous active-low.
REQ-002 clk  in  1  system clock; all state changes on its rising edge.
REQ-003 rst_n  in  1  asynchronous active-low reset.
REQ-004 dump  in  1  one-cycle start pulse from command decoder.
REQ-005 dump_ch  in  2  channel to dump: 00=ch1, 01=ch2, 10=ch3, 11=reserved.
REQ-006 ch1_AFEgain, ch2_AFEgain, ch3_AFEgain  in  3 each  current analog gain per channel.
REQ-007 trace_end  in  9  RAM address of last captured sample.
REQ-008 SPI_done  in  1  one-cycle pulse, SPI transaction complete.
REQ-009 resp_sent  in  1  one-cycle pulse, UART byte transmitted.
REQ-010 wrt_SPI  out  1  one-cycle SPI start pulse.
REQ-011 ss  out  3  SPI slave select; 3'b100 = calibration EEPROM.
REQ-012 SPI_data  out  16  SPI command word.
REQ-013 flopOffset, flopGain  out  1 each  one-cycle strobes to capture EEP_data as offset/gain.
REQ-014 ram_rd  out  1  RAM read enable; data valid one cycle later.
REQ-015 ram_addr  out  9  RAM read address.
REQ-016 send_resp  out  1  one-cycle UART send strobe for corrected RAM byte.
REQ-017 dump_busy  out  1  high from dump acceptance until dump_done.
REQ-018 dump_done  out  1  one-cycle completion pulse.

Function
REQ-019 States: IDLE, OFF_A, OFF_B, GAIN_A, GAIN_B, RD, SEND, WAIT, FIN.
REQ-020 IDLE + dump with dump_ch!=11 -> latch dump_ch, selected gain g[2:0], trace_end; go OFF_A with wrt_SPI=1, SPI_data={2'b00, dump_ch, g, 1'b0, 8'h00}.
REQ-021 IDLE + dump with dump_ch==11 -> FIN directly; no SPI, RAM or UART activity.
REQ-022 OFF_A + SPI_done -> OFF_B with wrt_SPI=1, SPI_data=16'h0000.
REQ-023 OFF_B + SPI_done -> flopOffset=1 same cycle; go GAIN_A with wrt_SPI=1, SPI_data={2'b00, ch, g, 1'b1, 8'h00}.
REQ-024 GAIN_A + SPI_done -> GAIN_B with wrt_SPI=1, SPI_data=16'h0000; GAIN_B + SPI_done -> flopGain=1 same cycle, go RD.
REQ-025 ss SHALL be 3'b100 in OFF_A..GAIN_B; 3'b100 otherwise too (no other slave driven); SPI_data held stable between wrt_SPI and SPI_done.
REQ-026 9-bit sample counter cnt cleared on dump acceptance; ram_addr = latched trace_end + 1 + cnt, modulo 512 (wraps 511->0).
REQ-027 RD: ram_rd=1 one cycle, go SEND; SEND: send_resp=1 one cycle, go WAIT.
REQ-028 WAIT + resp_sent: if cnt==511 go FIN, else cnt+1, go RD; exactly 512 bytes per dump.
REQ-029 FIN: dump_done=1 one cycle, go IDLE; dump_busy=0 in IDLE only.
REQ-030 dump while dump_busy SHALL be ignored; SPI_done/resp_sent outside their wait states ignored.
REQ-031 No timeouts; block waits indefinitely for SPI_done/resp_sent.
REQ-032 Gain/trace_end changes during a dump SHALL not affect it (latched values used).

Reset
REQ-033 rst_n low -> state IDLE, cnt=0, latched regs 0, all strobes 0, ss=3'b100, SPI_data=0, ram_addr=0, dump_busy=0, immediately and asynchronously.
REQ-034 Reset mid-dump aborts with no dump_done; next dump after release starts from OFF_A.

Verification
REQ-035 dump, dump_ch=01, ch2_AFEgain=3'b101 -> SPI words 16'h1A00, 16'h0000, 16'h1B00, 16'h0000; flopOffset then flopGain one cycle each.
REQ-036 trace_end=9'd100, full dump -> ram_addr sequence 101..511,0..100; 512 send_resp pulses; one dump_done after 512th resp_sent.
REQ-037 trace_end=9'd511 -> first ram_addr=0, last=511.
REQ-038 dump_ch=11 -> dump_done two cycles after dump, no wrt_SPI/ram_rd/send_resp.
REQ-039 second dump pulse during GAIN_A and during WAIT -> ignored, sequence unchanged.
REQ-040 rst_n low during WAIT at cnt=37 -> all outputs reset values; new dump restarts with offset read, cnt=0.
